// File: rtl/uart_chan_mux_pkg.sv
// Shared state encoding and tag constant for the UART channel multiplexer.
package uart_mux_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TAG,
        TAG_WAIT,
        DATA,
        DATA_WAIT
    } state_e;

    localparam logic [7:0] TAG_BASE = 8'hA0;

endpackage

// File: rtl/uart_chan_mux_if.sv
// Channel-input / UART-output bundle of the multiplexer; slave is the mux side.
interface uart_chan_mux_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8
);
    localparam int GW = $clog2(NUM_CH);

    logic [NUM_CH-1:0]        in_dv;
    logic [NUM_CH*DATA_W-1:0] in_byte;
    logic [NUM_CH-1:0]        in_full;
    logic                     tag_en;
    logic                     tx_busy;
    logic                     tx_done;
    logic                     tx_dv;
    logic [DATA_W-1:0]        tx_byte;
    logic [GW-1:0]            grant;
    logic [NUM_CH-1:0]        ovf;
    logic                     ovf_clr;

    modport slave (
        input  in_dv, in_byte, tag_en, tx_busy, tx_done, ovf_clr,
        output in_full, tx_dv, tx_byte, grant, ovf
    );

    modport master (
        output in_dv, in_byte, tag_en, tx_busy, tx_done, ovf_clr,
        input  in_full, tx_dv, tx_byte, grant, ovf
    );

endinterface

// File: rtl/sync_byte_fifo.sv
// Single-clock byte FIFO; head is visible the cycle after the first push.
// Push while full is dropped (full sampled before any same-cycle pop); pop while empty is ignored.
module sync_byte_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] din_i,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit separates full from empty when the indices coincide.
    logic [AW:0]       wr_q, wr_d;
    logic [AW:0]       rd_q, rd_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              do_push;
    logic              do_pop;

    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty   = (wr_q == rd_q);
    assign head    = mem_q[rd_q[AW-1:0]];
    assign do_push = push_i && !full;
    assign do_pop  = pop_i && !empty;

    always_comb begin
        wr_d = wr_q + (AW+1)'(do_push);
        rd_d = rd_q + (AW+1)'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q[AW-1:0]] <= din_i;
        end
    end

endmodule

// File: rtl/uart_chan_mux.sv
// Round-robin multiplexer of per-channel byte FIFOs onto one UART transmitter, optional tag byte.
// Write-to-tx_dv latency 2 cycles from idle; each byte waits for tx_done, full FIFOs drop and flag ovf.
module uart_chan_mux
    import uart_mux_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic            i_Clk,
    input  logic            rst,
    uart_chan_mux_if.slave  bus
);
    localparam int GW = $clog2(NUM_CH);

    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] empty;
    logic [NUM_CH-1:0] pop;
    logic [DATA_W-1:0] head [NUM_CH];

    state_e            state_q, state_d;
    logic [GW-1:0]     grant_q, grant_d;
    logic [DATA_W-1:0] tx_byte_q, tx_byte_d;
    logic [NUM_CH-1:0] ovf_q, ovf_d;
    logic              tx_dv;

    logic [GW-1:0]     cand;
    logic [GW-1:0]     rr_sel;
    logic              rr_hit;

    generate
        for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
            sync_byte_fifo #(
                .DATA_W (DATA_W),
                .DEPTH  (DEPTH)
            ) u_fifo (
                .clk    (i_Clk),
                .rst_n  (rst),
                .push_i (bus.in_dv[k]),
                .pop_i  (pop[k]),
                .din_i  (bus.in_byte[k*DATA_W +: DATA_W]),
                .full   (full[k]),
                .empty  (empty[k]),
                .head   (head[k])
            );
        end
    endgenerate

    // Scan starts one past the last grant so the previous winner is considered last.
    always_comb begin
        rr_hit = 1'b0;
        rr_sel = grant_q;
        cand   = grant_q;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = (cand == GW'(NUM_CH - 1)) ? '0 : cand + 1'b1;
            if (!rr_hit && !empty[cand]) begin
                rr_hit = 1'b1;
                rr_sel = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        tx_byte_d = tx_byte_q;
        pop       = '0;
        tx_dv     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rr_hit && !bus.tx_busy) begin
                    grant_d = rr_sel;
                    if (bus.tag_en) begin
                        state_d   = TAG;
                        tx_byte_d = DATA_W'(TAG_BASE) | DATA_W'(rr_sel);
                    end else begin
                        state_d   = DATA;
                        tx_byte_d = head[rr_sel];
                    end
                end
            end
            TAG: begin
                tx_dv   = 1'b1;
                state_d = TAG_WAIT;
            end
            TAG_WAIT: begin
                if (bus.tx_done) begin
                    state_d   = DATA;
                    tx_byte_d = head[grant_q];
                end
            end
            DATA: begin
                tx_dv         = 1'b1;
                pop[grant_q]  = 1'b1;
                state_d       = DATA_WAIT;
            end
            DATA_WAIT: begin
                if (bus.tx_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A fresh overflow wins over a same-cycle clear.
    always_comb begin
        ovf_d = (bus.ovf_clr ? '0 : ovf_q) | (bus.in_dv & full);
    end

    always_ff @(posedge i_Clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            grant_q   <= GW'(NUM_CH - 1);
            tx_byte_q <= '0;
            ovf_q     <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            tx_byte_q <= tx_byte_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.in_full = full;
    assign bus.tx_dv   = tx_dv;
    assign bus.tx_byte = tx_byte_q;
    assign bus.grant   = grant_q;
    assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_uart_chan_mux.sv
// Scoreboard bench for uart_chan_mux: per-channel expected-byte queues, UART responder, directed and random phases.
module tb_uart_chan_mux;
    localparam int NUM_CH = 4;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;

    typedef struct packed {
        logic [31:0] ts;
        logic [7:0]  b;
    } ent_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    uart_chan_mux_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

    uart_chan_mux #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .i_Clk (clk),
        .rst   (rst_n),
        .bus   (bus)
    );

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   dv_cnt = 0;
    int   last_dv_cyc = 0;
    int   grant_m = NUM_CH - 1;
    int   pick;
    int   uart_cnt = 0;
    int   uart_ext = 0;
    int   uart_ext_set = 0;
    bit   pending = 0, exp_data = 0, prev_busy = 0, prev_tag = 0;
    bit   uart_dv_s = 0, uart_busy = 0, busy_force = 0, rand_uart = 0;
    logic [7:0]        held;
    logic [NUM_CH-1:0] ovf_m = '0;
    logic [NUM_CH-1:0] full_m;
    logic [NUM_CH-1:0] drops;
    ent_t              mq [NUM_CH][$];
    ent_t              e;
    logic [7:0]        txlog [$];

    assign bus.tx_busy = uart_busy | busy_force;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 60)
                $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Round-robin choice among channels holding a byte written at least two cycles ago.
    function automatic int rr_pick(input int c);
        for (int i = 1; i <= NUM_CH; i++) begin
            int k;
            k = (grant_m + i) % NUM_CH;
            if (mq[k].size() > 0 && int'(mq[k][0].ts) <= c - 2) return k;
        end
        return -1;
    endfunction

    function automatic bit model_empty();
        if (pending || exp_data) return 1'b0;
        for (int k = 0; k < NUM_CH; k++) if (mq[k].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic pop_check(input int k);
        check("byte_available", 32'(mq[k].size() > 0), 1);
        if (mq[k].size() > 0) begin
            e = mq[k].pop_front();
            check("data_byte", 32'(bus.tx_byte), 32'(e.b));
        end
    endtask

    // Monitor and reference model, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_tx_dv", 32'(bus.tx_dv), 0);
            check("rst_tx_byte", 32'(bus.tx_byte), 0);
            check("rst_grant", 32'(bus.grant), NUM_CH - 1);
            check("rst_ovf", 32'(bus.ovf), 0);
            check("rst_in_full", 32'(bus.in_full), 0);
            for (int k = 0; k < NUM_CH; k++) mq[k].delete();
            ovf_m = '0; grant_m = NUM_CH - 1;
            pending = 0; exp_data = 0; prev_busy = 0; prev_tag = 0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) full_m[k] = (mq[k].size() == DEPTH);
            check("in_full", 32'(bus.in_full), 32'(full_m));
            check("ovf", 32'(bus.ovf), 32'(ovf_m));
            if (bus.tx_dv) begin
                dv_cnt++;
                last_dv_cyc = cyc;
                txlog.push_back(bus.tx_byte);
                check("tx_dv_overlap", 32'(pending), 0);
                if (exp_data) begin
                    check("data_grant", 32'(bus.grant), grant_m);
                    pop_check(grant_m);
                    exp_data = 0;
                end else begin
                    check("arb_while_busy", 32'(prev_busy), 0);
                    pick = rr_pick(cyc);
                    check("arb_grant", 32'(bus.grant), pick);
                    if (pick >= 0) begin
                        grant_m = pick;
                        if (prev_tag) begin
                            check("tag_byte", 32'(bus.tx_byte), 32'h0A0 | pick);
                            exp_data = 1;
                        end else begin
                            pop_check(pick);
                        end
                    end
                end
                pending = 1;
                held = bus.tx_byte;
            end else if (pending) begin
                check("tx_byte_hold", 32'(bus.tx_byte), 32'(held));
            end
            if (bus.tx_done) pending = 0;
            check("grant", 32'(bus.grant), grant_m);
            drops = '0;
            for (int k = 0; k < NUM_CH; k++) begin
                if (bus.in_dv[k]) begin
                    if (full_m[k]) drops[k] = 1'b1;
                    else mq[k].push_back(ent_t'({32'(cyc), bus.in_byte[k*8 +: 8]}));
                end
            end
            ovf_m = (bus.ovf_clr ? '0 : ovf_m) | drops;
            prev_busy = bus.tx_busy;
            prev_tag  = bus.tag_en;
        end
    end

    // UART responder: busy from the cycle after tx_dv, tx_done pulse a few cycles later.
    initial begin
        bus.tx_done = 1'b0;
        forever begin
            @(negedge clk);
            uart_dv_s = bus.tx_dv;
            @(posedge clk);
            #1;
            bus.tx_done = 1'b0;
            if (!rst_n) begin
                uart_cnt = 0; uart_ext = 0; uart_busy = 0;
            end else if (uart_dv_s) begin
                uart_busy    = 1;
                uart_cnt     = (rand_uart ? int'($urandom_range(2, 7)) : 5) - 1;
                uart_ext_set = rand_uart ? int'($urandom_range(0, 3)) : 0;
            end else if (uart_cnt > 0) begin
                uart_cnt--;
                if (uart_cnt == 0) begin
                    bus.tx_done = 1'b1;
                    uart_ext    = uart_ext_set;
                    uart_busy   = (uart_ext_set != 0);
                end
            end else if (uart_ext > 0) begin
                uart_ext--;
                if (uart_ext == 0) uart_busy = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        bus.in_dv   = '0;
        bus.in_byte = '0;
        bus.ovf_clr = 1'b0;
    endtask

    task automatic wr(input int ch, input logic [7:0] b);
        bus.in_dv[ch]          = 1'b1;
        bus.in_byte[ch*8 +: 8] = b;
    endtask

    task automatic wait_dv(input int target, input int limit, input string name);
        int t;
        t = 0;
        while (dv_cnt < target && t < limit) begin tick(); t++; end
        check(name, 32'(dv_cnt >= target), 1);
    endtask

    task automatic wait_idle(input int limit);
        int t;
        t = 0;
        while (!model_empty() && t < limit) begin tick(); t++; end
        check("drain", 32'(model_empty()), 1);
        repeat (4) tick();
    endtask

    initial begin
        #200000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wcyc, n0, rate;
        bus.in_dv = '0; bus.in_byte = '0; bus.tag_en = 1'b0; bus.ovf_clr = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Single byte, no tag: two-cycle latency, grant 0.
        n0 = dv_cnt;
        wr(0, 8'h41); wcyc = cyc; tick();
        wait_dv(n0 + 1, 20, "latency_wait");
        check("latency", 32'(last_dv_cyc - wcyc), 2);
        check("first_byte", 32'(txlog[txlog.size()-1]), 32'h41);
        check("first_grant", 32'(bus.grant), 0);
        wait_idle(100);

        // Tagged byte on channel 2.
        bus.tag_en = 1'b1; txlog.delete();
        wr(2, 8'h55); tick();
        wait_idle(100);
        check("tag_seq_len", 32'(txlog.size()), 2);
        check("tag_seq0", 32'(txlog[0]), 32'hA2);
        check("tag_seq1", 32'(txlog[1]), 32'h55);
        bus.tag_en = 1'b0;

        // Round-robin order from reset.
        rst_n = 1'b0; tick(); tick(); rst_n = 1'b1; tick();
        txlog.delete();
        for (int k = 0; k < NUM_CH; k++) wr(k, 8'(8'h10 + k));
        tick();
        for (int k = 0; k < NUM_CH; k++) wr(k, 8'(8'h20 + k));
        tick();
        wait_idle(400);
        check("rr_len", 32'(txlog.size()), 8);
        for (int i = 0; i < 8; i++)
            check("rr_order", 32'(txlog[i]), (i < 4) ? 32'h10 + i : 32'h20 + i - 4);

        // Fill channel 1 with the transmitter held busy, then overflow.
        busy_force = 1; tick();
        for (int i = 0; i < 17; i++) begin
            wr(1, 8'(8'h60 + i)); tick();
            if (i == 14) check("not_full_15", 32'(bus.in_full[1]), 0);
            if (i == 15) check("full_16", 32'(bus.in_full[1]), 1);
        end
        check("ovf_set", 32'(bus.ovf), 32'h2);
        bus.ovf_clr = 1'b1; tick();
        check("ovf_clr", 32'(bus.ovf), 0);
        wr(1, 8'h77); bus.ovf_clr = 1'b1; tick();
        check("ovf_set_beats_clr", 32'(bus.ovf), 32'h2);
        bus.ovf_clr = 1'b1; tick();
        check("ovf_clr2", 32'(bus.ovf), 0);
        busy_force = 0;
        for (int i = 0; i < 6; i++) begin wr(1, 8'(8'h80 + i)); tick(); end
        wait_idle(600);
        bus.ovf_clr = 1'b1; tick();

        // Reset during DATA_WAIT aborts the transfer and flushes the FIFOs.
        n0 = dv_cnt;
        for (int i = 0; i < 3; i++) begin wr(3, 8'(8'hC0 + i)); tick(); end
        wait_dv(n0 + 1, 30, "pre_rst_dv");
        tick(); tick();
        rst_n = 1'b0; tick(); tick(); rst_n = 1'b1;
        n0 = dv_cnt;
        repeat (30) tick();
        check("no_dv_after_rst", 32'(dv_cnt - n0), 0);
        check("full_after_rst", 32'(bus.in_full), 0);

        // Random traffic with varying load, tag mode and transmitter timing.
        rand_uart = 1;
        for (int c = 0; c < 3000; c++) begin
            rate = (c / 500) % 3;
            for (int k = 0; k < NUM_CH; k++)
                if ($urandom_range(0, 31) < ((rate == 0) ? 1 : (rate == 1) ? 3 : 10))
                    wr(k, 8'($urandom));
            if ($urandom_range(0, 29) == 0) bus.tag_en = ~bus.tag_en;
            if ($urandom_range(0, 63) == 0) bus.ovf_clr = 1'b1;
            if ($urandom_range(0, 199) == 0) busy_force = ~busy_force;
            tick();
        end
        busy_force = 0;
        wait_idle(5000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
